// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample rate and baud divider helper.
package uart_pkg;

  localparam int OS_RATE = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OS_RATE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and pulses on the last count; en_i low holds it at 0.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (!en_i || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampled 8N1 receiver with 3-sample majority vote, start-glitch rejection and stop-bit check.
// IDLE: wait for low line | START: confirm start bit | DATA: shift 8 bits LSB-first | STOP: check stop bit
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DIV      = baud_div(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx,
  output logic       rx_done,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       busy
);

  logic tick;
  logic sync1_q, sync2_q, rxs;
  rx_state_t state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] samp_q, samp_d;
  logic       vote_q, vote_d, vote_now;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic       done_q, done_d, ferr_q, ferr_d;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en),
    .tick_o (tick)
  );

  assign rxs = sync2_q;
  // samples 7 and 8 are held in samp_q; sample 9 is the live line value
  assign vote_now = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    if (!en) begin
      state_d    = IDLE;
      samp_cnt_d = '0;
      bit_cnt_d  = '0;
      samp_d     = '0;
    end else if (tick) begin
      if (state_q != IDLE) samp_cnt_d = samp_cnt_q + 4'd1;
      if (samp_cnt_q == 4'd7 || samp_cnt_q == 4'd8) samp_d = {samp_q[0], rxs};
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d    = START;
            samp_cnt_d = '0;
          end
        end
        START: begin
          if (samp_cnt_q == 4'd9 && vote_now) begin
            state_d    = IDLE;
            samp_cnt_d = '0;
          end else if (samp_cnt_q == 4'd15) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (samp_cnt_q == 4'd9) vote_d = vote_now;
          if (samp_cnt_q == 4'd15) begin
            shift_d   = {vote_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          // decide at the stop-bit centre so a following start bit is not missed
          if (samp_cnt_q == 4'd9) begin
            if (vote_now) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d    = IDLE;
            samp_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      vote_q     <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_data   = data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed and random frame checks for uart_rx_os16 at DIV=1 (16 clk per bit).
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset, en, rx;
  logic       rx_done, frame_err, busy;
  logic [7:0] rx_data;

  uart_rx_os16 #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rx        (rx),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          both_hi = 0;
  longint      cyc = 0;
  longint      done_cyc = 0;
  longint      start_cyc = 0;
  logic [8:0]  obs_q[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  last_good;

  always @(posedge clk) cyc <= cyc + 1;

  // event record: {is_frame_err, rx_data}
  always @(negedge clk) begin
    if (rx_done) begin
      obs_q.push_back({1'b0, rx_data});
      done_cyc = cyc;
    end
    if (frame_err) obs_q.push_back({1'b1, rx_data});
    if (rx_done && frame_err) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  // reference: a good stop delivers the byte, a bad stop reports the previous good byte
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    start_cyc = cyc;
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    tx_bit(stop_ok);
    if (stop_ok) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, k < 400, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    int         gap, k;
    longint     lat;

    reset = 1'b1; en = 1'b0; rx = 1'b1; last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_done", rx_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0; en = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1);
    wait_idle("a5");
    compare_events("a5");
    lat = done_cyc - start_cyc;
    check("a5_latency", (lat >= 156 && lat <= 158), 1);
    check("a5_rx_data", rx_data, last_good);

    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_idle("b2b");
    compare_events("b2b");
    check("b2b_rx_data", rx_data, last_good);

    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    wait_idle("badstop");
    compare_events("badstop");
    check("badstop_rx_data", rx_data, last_good);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", busy, 1);
    rx = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 16) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_clear", k < 16, 1);
    repeat (20) @(negedge clk);
    compare_events("glitch");

    b = 8'h6B;
    tx_bit(1'b0);
    for (int i = 0; i < 3; i++) tx_bit(b[i]);
    rx = b[3];
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_busy", busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    compare_events("en_abort");
    send_frame(8'h81, 1'b1);
    wait_idle("en_81");
    compare_events("en_81");
    check("en_81_rx_data", rx_data, last_good);

    b = 8'hC7;
    tx_bit(1'b0);
    for (int i = 0; i < 5; i++) tx_bit(b[i]);
    rx = b[5];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    last_good = 8'h00;
    check("midrst_rx_data", rx_data, last_good);
    check("midrst_rx_done", rx_done, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    compare_events("midrst_abort");
    send_frame(8'h12, 1'b1);
    wait_idle("rst_12");
    compare_events("rst_12");
    check("rst_12_rx_data", rx_data, last_good);

    for (int f = 0; f < 24; f++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      rx = 1'b1;
      gap = ok ? int'($urandom_range(0, 12)) : 24 + int'($urandom_range(0, 8));
      repeat (gap) @(negedge clk);
    end
    wait_idle("rand");
    compare_events("rand");
    check("rand_rx_data", rx_data, last_good);
    check("never_both", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
